// File: rtl/ibex_fetch_arbiter.sv
// Two-requester instruction-fetch arbiter onto a single req/gnt/rvalid bus.
// Round-robin on ties; an ID FIFO routes in-order responses back to their owners.
module ibex_fetch_arbiter #(
  parameter int unsigned NUM_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        a_req_i,
  input  logic [31:0] a_addr_i,
  output logic        a_gnt_o,
  output logic        a_rvalid_o,
  input  logic        b_req_i,
  input  logic [31:0] b_addr_i,
  output logic        b_gnt_o,
  output logic        b_rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        busy_o,
  output logic        unexp_rvalid_o
);

  localparam int unsigned PW = (NUM_OUTSTANDING > 1) ? $clog2(NUM_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(NUM_OUTSTANDING + 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_OUTSTANDING);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_OUTSTANDING - 1);

  typedef enum logic {ARB, HOLD} state_e;

  // Owner encoding: 0 = requester A, 1 = requester B
  state_e                     state_q, state_d;
  logic                       sel_q, sel_d;
  logic                       last_q, last_d;
  logic                       unexp_q, unexp_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [PW-1:0]              wptr_q, wptr_d, rptr_q, rptr_d;
  logic [NUM_OUTSTANDING-1:0] ids_q, ids_d;

  logic pop, push, can_issue, arb_sel, sel, req, head;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      unexp_q <= 1'b0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ids_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      unexp_q <= unexp_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ids_q   <= ids_d;
    end
  end

  // Output / datapath decode; reset gating keeps the bus quiet while rst_ni is low
  always_comb begin
    pop       = instr_rvalid_i & (cnt_q != '0);
    can_issue = (cnt_q != FULL) | pop;
    arb_sel   = (a_req_i & b_req_i) ? ~last_q : (b_req_i & ~a_req_i);
    sel       = (state_q == HOLD) ? sel_q : arb_sel;
    req       = rst_ni & ((state_q == HOLD) | ((a_req_i | b_req_i) & can_issue));
    push      = req & instr_gnt_i;
    head      = ids_q[rptr_q];

    instr_req_o    = req;
    instr_addr_o   = rst_ni ? {(sel ? b_addr_i[31:2] : a_addr_i[31:2]), 2'b00} : 32'h0;
    a_gnt_o        = push & ~sel;
    b_gnt_o        = push & sel;
    a_rvalid_o     = pop & ~head;
    b_rvalid_o     = pop & head;
    rdata_o        = instr_rdata_i;
    err_o          = instr_err_i;
    busy_o         = req | (cnt_q != '0);
    unexp_rvalid_o = unexp_q;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = push ? sel : last_q;
    unexp_d = unexp_q | (instr_rvalid_i & (cnt_q == '0));
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    ids_d   = ids_q;
    case (state_q)
      ARB: if (req && !instr_gnt_i) begin
        state_d = HOLD;
        sel_d   = sel;
      end
      HOLD: if (instr_gnt_i) state_d = ARB;
      default: state_d = ARB;
    endcase
    if (push) begin
      ids_d[wptr_q] = sel;
      wptr_d = (wptr_q == LAST_IDX) ? '0 : wptr_q + 1'b1;
    end
    if (pop) rptr_d = (rptr_q == LAST_IDX) ? '0 : rptr_q + 1'b1;
  end

endmodule
